// File: rtl/demux_pkg.sv
// Shared defaults for the registered 1-to-N bit distributor.
package demux_pkg;
  localparam int   DEF_SEL_W   = 9;
  localparam int   DEF_N       = 1 << DEF_SEL_W;
  localparam logic DEF_CLR_VAL = 1'b0;
endpackage

// File: rtl/demux_ptr_ctr.sv
// Write pointer for the distributor: load/increment priority and wrap pulse.
module demux_ptr_ctr
  import demux_pkg::*;
#(
  parameter int SEL_W = DEF_SEL_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [SEL_W-1:0] sel,
  input  logic             we,
  input  logic             auto_inc,
  input  logic             ptr_ld,
  input  logic             clr,
  output logic [SEL_W-1:0] ptr,
  output logic             wrap
);

  logic             adv;
  logic [SEL_W-1:0] base;
  logic [SEL_W-1:0] ptr_nxt;
  logic             wrap_nxt;

  // A load replaces the pointer before any advance, so load+write increments from sel.
  always_comb begin
    adv      = we & auto_inc & ~clr;
    base     = ptr_ld ? sel : ptr;
    ptr_nxt  = base;
    wrap_nxt = 1'b0;
    if (adv) begin
      ptr_nxt  = base + {{(SEL_W-1){1'b0}}, 1'b1};
      wrap_nxt = &base;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr  <= '0;
      wrap <= 1'b0;
    end else begin
      ptr  <= ptr_nxt;
      wrap <= wrap_nxt;
    end
  end

endmodule

// File: rtl/demux_1x512_reg.sv
// Registered 1-to-N bit distributor: one serial bit per cycle into an N-flop bank.
module demux_1x512_reg
  import demux_pkg::*;
#(
  parameter int   SEL_W   = DEF_SEL_W,
  parameter logic CLR_VAL = DEF_CLR_VAL,
  localparam int  N       = 1 << SEL_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in,
  input  logic [SEL_W-1:0] sel,
  input  logic             we,
  input  logic             auto_inc,
  input  logic             ptr_ld,
  input  logic             clr,
  output logic [N-1:0]     out,
  output logic [SEL_W-1:0] ptr,
  output logic             wrap
);

  logic [SEL_W-1:0] addr;

  demux_ptr_ctr #(.SEL_W(SEL_W)) u_ptr (
    .clk      (clk),
    .rst_n    (rst_n),
    .sel      (sel),
    .we       (we),
    .auto_inc (auto_inc),
    .ptr_ld   (ptr_ld),
    .clr      (clr),
    .ptr      (ptr),
    .wrap     (wrap)
  );

  always_comb begin
    addr = sel;
    if (!ptr_ld && auto_inc) addr = ptr;
  end

  for (genvar i = 0; i < N; i++) begin : g_bit
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        out[i] <= CLR_VAL;
      end else if (clr) begin
        out[i] <= CLR_VAL;
      end else if (we && (addr == SEL_W'(i))) begin
        out[i] <= in;
      end
    end
  end

endmodule

// File: doc/demux_1x512_reg.md
Name: demux_1x512_reg

Overview:
- Registered 1-to-N bit distributor; the write-side counterpart of the registered N:1 mux tree.
- Routes a single serial data bit into one of N output flops, addressed either directly by `sel` or by an internal auto-incrementing pointer.
- Used to load wide test vectors / configuration words one bit per cycle.
- Bank output feeds the mux tree for loopback checking.

Parameters:
- SEL_W, 9, address width; N = 2**SEL_W outputs (512 at default).
- CLR_VAL, 1'b0, value every output bit takes on reset and on `clr`.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, asynchronous assert, active-low.
- in  input  1  serial data bit to distribute.
- sel  input  SEL_W  direct address; also the load value for the pointer.
- we  input  1  write enable; one bit written per cycle when high.
- auto_inc  input  1  1 = address from pointer, 0 = address from `sel`.
- ptr_ld  input  1  load pointer from `sel`.
- clr  input  1  synchronous clear of the output bank.
- out  output  N  registered output bank.
- ptr  output  SEL_W  current pointer value.
- wrap  output  1  one-cycle pulse after a pointer wrap.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - out = all bits CLR_VAL; ptr = 0; wrap = 0.
  - Deassertion takes effect on the next clk edge; no synchronizer inside.
- Effective address per cycle: addr = ptr_ld ? sel : (auto_inc ? ptr : sel).
- Write:
  - On a clk edge with we=1 and clr=0: out[addr] <= in.
  - All other bits hold.
  - Latency 1 cycle: `in` sampled at edge k appears on out[addr] after edge k.
- Clear: clr=1 at an edge sets out = all CLR_VAL. clr has priority over we; the write is dropped.
- Pointer next-state, in priority order:
  - ptr_ld=1: ptr <= sel. If we=1 and auto_inc=1, the write uses sel and ptr <= sel+1 (mod N).
  - we=1, auto_inc=1, clr=0: ptr <= ptr+1, wrapping N-1 -> 0.
  - Otherwise ptr holds. A dropped write (clr=1) does not advance ptr.
  - In direct mode (auto_inc=0) ptr is unaffected by writes.
- wrap:
  - Registered; 1 for exactly the one cycle after an edge where ptr advanced from N-1 to 0.
  - This includes the ptr_ld+write case where sel = N-1.
  - Otherwise 0. Never asserted in direct mode or by ptr_ld alone.
- Pointer arithmetic: SEL_W-bit unsigned, natural modulo-N wrap, no saturation.
- Reset mid-sequence: all state lost immediately. A following auto_inc stream restarts at address 0.
- Implementation: no combinational path from inputs to outputs; `out`, `ptr` and `wrap` are all flops.

Decomposition:
- Shared package `demux_pkg` holds:
  - SEL_W default = 9;
  - localparam N = 1 << SEL_W;
  - CLR_VAL default.
- One sub-module, `demux_ptr_ctr`: pointer register, load/increment priority and wrap-pulse generation.
- The top module holds the generate loop of N write-enabled flops.

Test Plan:
- Reset/clear:
  - Assert rst_n=0 mid-stream, then release -> out=0, ptr=0, wrap=0 immediately.
  - With out fully set, drive clr=1, we=1, in=1, auto_inc=1 -> out=0, ptr unchanged.
- Direct write: auto_inc=0, we=1, sel=0x1A5, in=1 for one cycle -> next cycle out[421]=1, all other bits 0, ptr stays 0.
- Auto stream:
  - ptr_ld with sel=0x1FE, then 4 writes of in=1,0,1,1 with auto_inc=1 -> out[510]=1, out[511]=0, out[0]=1, out[1]=1, ptr=2.
  - wrap=1 only in the cycle following the write to bit 511.
- Load+write same cycle: ptr=5, ptr_ld=1, sel=0x1FF, we=1, auto_inc=1, in=1 -> out[511]=1, ptr=0, wrap pulses once.
- Full-bank loopback:
  - Write a 512-bit LFSR pattern in auto mode, then read it back through the 512:1 registered mux tree sweeping sel 0..511.
  - Every bit must match, accounting for the tree's 1-cycle leaf latency.
  - wrap is seen exactly once per 512 writes.
